// File: rtl/stream_demux_1ton_if.sv
// Handshake bundle for stream_demux_1ton: one input stream plus N_CH output channels.
// The master modport is the demux side; the slave modport is the surrounding producer/consumers.
interface stream_demux_1ton_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SEL_W  = 2
);

  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_W-1:0]      s_data;
  logic [SEL_W-1:0]       s_sel;
  logic [N_CH-1:0]        m_valid;
  logic [N_CH-1:0]        m_ready;
  logic [N_CH*DATA_W-1:0] m_data;

  modport master (
    input  s_valid,
    input  s_data,
    input  s_sel,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data
  );

  modport slave (
    output s_valid,
    output s_data,
    output s_sel,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1:N stream demux: addressed (mode=0) or round-robin (mode=1) routing into
// one-entry per-channel holding registers. Define DEMUX_STATS_EN to add the acc_cnt counter.
module stream_demux_1ton #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  stream_demux_1ton_if.master bus,
  output logic                sel_err
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]         acc_cnt
`endif
);

  localparam int unsigned      SEL_N   = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] tgt_c;
  logic             tgt_ok_c;
  logic [N_CH-1:0]  free_c;
  logic [SEL_N-1:0] free_ext_c;
  logic             acc_c;
  logic [N_CH-1:0]  wr_c;

  // Target channel and whether it exists; out-of-range only reachable in addressed mode.
  assign tgt_c    = mode ? rr_ptr : bus.s_sel;
  assign tgt_ok_c = (32'(tgt_c) < N_CH);

  // A holding register is free when empty or being drained this cycle.
  assign free_c     = ~bus.m_valid | bus.m_ready;
  assign free_ext_c = SEL_N'(free_c);

  assign bus.s_ready = tgt_ok_c ? free_ext_c[tgt_c] : 1'b1;
  assign acc_c       = bus.s_valid & bus.s_ready;

  always_comb begin
    wr_c = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      wr_c[k] = acc_c & tgt_ok_c & (tgt_c == SEL_W'(k));
    end
  end

  // Channel registers: a write wins over a drain so a ready consumer sees full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_valid <= '0;
      bus.m_data  <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (wr_c[k]) begin
          bus.m_valid[k]                 <= 1'b1;
          bus.m_data[k*DATA_W +: DATA_W] <= bus.s_data;
        end else if (bus.m_ready[k]) begin
          bus.m_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer never skips a busy channel; it only moves on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= acc_c & ~tgt_ok_c;
      if (acc_c && mode) begin
        rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + SEL_W'(1);
      end
    end
  end

`ifdef DEMUX_STATS_EN
  // Saturating count of accepted words, discarded ones included.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (acc_c && (acc_cnt != 16'hFFFF)) begin
      acc_cnt <= acc_cnt + 16'd1;
    end
  end
`endif

endmodule
